// File: rtl/stim_sequencer.sv
// Table-driven stimulus sequencer: replays up to DEPTH {pattern, hold-time} entries
// onto N_CH channel outputs, one-shot or looping, with abort and a done pulse.
module stim_sequencer #(
    parameter int              N_CH     = 3,
    parameter int              DEPTH    = 8,
    parameter int              DLY_W    = 16,
    parameter logic [N_CH-1:0] IDLE_PAT = '1
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Abort,
    input  logic                       Loop,
    input  logic [$clog2(DEPTH):0]     Len,
    input  logic                       Wr_en,
    input  logic [$clog2(DEPTH)-1:0]   Wr_addr,
    input  logic [DLY_W-1:0]           Wr_delay,
    input  logic [N_CH-1:0]            Wr_pat,
    output logic [N_CH-1:0]            Out,
    output logic                       Busy,
    output logic                       Done,
    output logic [$clog2(DEPTH)-1:0]   Step
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0]      LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]    STEP_ONE = AW'(1);
    localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q;
    logic [N_CH-1:0]  out_q;
    logic             busy_q;
    logic             done_q;
    logic [AW-1:0]    step_q;
    logic [DLY_W-1:0] cnt_q;
    logic [AW:0]      len_q;
    logic             loop_q;

    logic [DLY_W-1:0] dly_tab_q [DEPTH];
    logic [N_CH-1:0]  pat_tab_q [DEPTH];

    logic             tab_we;
    logic             len_ok;
    logic             last_entry;
    logic [AW-1:0]    step_d;
    logic [DLY_W-1:0] first_dly;
    logic [N_CH-1:0]  first_pat;

    assign tab_we = Wr_en && (state_q == S_IDLE);

    // Table entries live in resettable registers so Reset can restore every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tab
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    dly_tab_q[gi] <= '0;
                    pat_tab_q[gi] <= IDLE_PAT;
                end else if (tab_we && (Wr_addr == AW'(gi))) begin
                    dly_tab_q[gi] <= Wr_delay;
                    pat_tab_q[gi] <= Wr_pat;
                end
            end
        end
    endgenerate

    // Forward a same-cycle write to entry 0 so Start sees the freshly written value.
    assign first_dly  = (tab_we && (Wr_addr == '0)) ? Wr_delay : dly_tab_q[0];
    assign first_pat  = (tab_we && (Wr_addr == '0)) ? Wr_pat   : pat_tab_q[0];
    assign len_ok     = (Len != '0) && (Len <= LEN_MAX);
    assign last_entry = ({1'b0, step_q} == (len_q - LEN_ONE));
    assign step_d     = last_entry ? '0 : (step_q + STEP_ONE);

    function automatic logic [DLY_W-1:0] hold_of(input logic [DLY_W-1:0] d);
        return (d == '0) ? DLY_ONE : d;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            out_q   <= IDLE_PAT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start && !Abort) begin
                        if (len_ok) begin
                            state_q <= S_RUN;
                            out_q   <= first_pat;
                            busy_q  <= 1'b1;
                            step_q  <= '0;
                            cnt_q   <= hold_of(first_dly);
                            len_q   <= Len;
                            loop_q  <= Loop;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (Abort) begin
                        state_q <= S_IDLE;
                        out_q   <= IDLE_PAT;
                        busy_q  <= 1'b0;
                        step_q  <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q <= DLY_ONE) begin
                        if (last_entry && !loop_q) begin
                            state_q <= S_IDLE;
                            out_q   <= IDLE_PAT;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            step_q  <= '0;
                            cnt_q   <= '0;
                        end else begin
                            step_q <= step_d;
                            out_q  <= pat_tab_q[step_d];
                            cnt_q  <= hold_of(dly_tab_q[step_d]);
                        end
                    end else begin
                        cnt_q <= cnt_q - DLY_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Out  = out_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Step = step_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: one-shot, loop/abort, zero delay, bad Len,
// writes/Start during RUN, and reset mid-run, all against hand-computed values.
module tb_stim_sequencer;
    localparam int N_CH  = 3;
    localparam int DEPTH = 8;
    localparam int DLY_W = 16;
    localparam int AW    = 3;

    logic              Clk = 1'b0;
    logic              Reset, Start, Abort, Loop, Wr_en;
    logic [AW:0]       Len;
    logic [AW-1:0]     Wr_addr;
    logic [DLY_W-1:0]  Wr_delay;
    logic [N_CH-1:0]   Wr_pat;
    logic [N_CH-1:0]   Out;
    logic              Busy, Done;
    logic [AW-1:0]     Step;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_seq[$];
    logic [2:0] exp_step[$];

    stim_sequencer #(.N_CH(N_CH), .DEPTH(DEPTH), .DLY_W(DLY_W), .IDLE_PAT(3'b111)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Loop(Loop), .Len(Len),
        .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_delay(Wr_delay), .Wr_pat(Wr_pat),
        .Out(Out), .Busy(Busy), .Done(Done), .Step(Step)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int addr, input int dly, input logic [2:0] pat);
        Wr_en = 1'b1; Wr_addr = AW'(addr); Wr_delay = DLY_W'(dly); Wr_pat = pat;
        tick();
        Wr_en = 1'b0;
    endtask

    task automatic start(input int len, input logic lp);
        Start = 1'b1; Len = (AW+1)'(len); Loop = lp;
        tick();
        Start = 1'b0; Wr_en = 1'b0;
    endtask

    // Called right after the Start edge; walks exp_seq (and exp_step if filled) then expects completion.
    task automatic expect_seq(input string tag);
        for (int i = 0; i < exp_seq.size(); i++) begin
            check({tag, "_out"}, 32'(Out), 32'(exp_seq[i]));
            check({tag, "_busy"}, 32'(Busy), 32'd1);
            check({tag, "_done"}, 32'(Done), 32'd0);
            if (exp_step.size() == exp_seq.size())
                check({tag, "_step"}, 32'(Step), 32'(exp_step[i]));
            tick();
            Wr_en = 1'b0; Start = 1'b0;
        end
        check({tag, "_end_out"}, 32'(Out), 32'h7);
        check({tag, "_end_busy"}, 32'(Busy), 32'd0);
        check({tag, "_end_done"}, 32'(Done), 32'd1);
        check({tag, "_end_step"}, 32'(Step), 32'd0);
        tick();
        check({tag, "_done_clr"}, 32'(Done), 32'd0);
        $display("txn %s: %0d entries cycles checked", tag, exp_seq.size());
        exp_seq.delete();
        exp_step.delete();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Loop = 1'b0; Len = '0;
        Wr_en = 1'b0; Wr_addr = '0; Wr_delay = '0; Wr_pat = '0;
        tick();
        tick();
        check("rst_out", 32'(Out), 32'h7);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_step", 32'(Step), 32'd0);
        Reset = 1'b0;
        $display("txn reset");

        wr(0, 2, 3'b110);
        wr(1, 3, 3'b111);
        wr(2, 1, 3'b101);

        // One-shot: 6,6,7,7,7,5 then idle with Done.
        start(3, 1'b0);
        exp_seq  = '{3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b101};
        exp_step = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
        expect_seq("oneshot");

        // Loop with abort during the 9th cycle.
        begin
            logic [2:0] ls [9] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0, 3'd1};
            logic [2:0] lo [9] = '{3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b101, 3'b110, 3'b110, 3'b111};
            start(3, 1'b1);
            for (int i = 0; i < 9; i++) begin
                check("loop_step", 32'(Step), 32'(ls[i]));
                check("loop_out", 32'(Out), 32'(lo[i]));
                check("loop_done", 32'(Done), 32'd0);
                if (i == 8) Abort = 1'b1;
                tick();
            end
            Abort = 1'b0;
            check("abort_out", 32'(Out), 32'h7);
            check("abort_busy", 32'(Busy), 32'd0);
            check("abort_done", 32'(Done), 32'd0);
            check("abort_step", 32'(Step), 32'd0);
            $display("txn loop+abort");
        end

        // Zero delay on entry 0, written in the same cycle as Start.
        Wr_en = 1'b1; Wr_addr = '0; Wr_delay = '0; Wr_pat = 3'b010;
        start(1, 1'b0);
        exp_seq = '{3'b010};
        expect_seq("zero_dly");

        // Invalid lengths: Done pulse only.
        for (int k = 0; k < 2; k++) begin
            start((k == 0) ? 0 : 9, 1'b0);
            check("badlen_done", 32'(Done), 32'd1);
            check("badlen_busy", 32'(Busy), 32'd0);
            check("badlen_out", 32'(Out), 32'h7);
            tick();
            check("badlen_done_clr", 32'(Done), 32'd0);
            check("badlen_busy2", 32'(Busy), 32'd0);
            $display("txn badlen %0d", (k == 0) ? 0 : 9);
        end

        // Start together with Abort in IDLE stays idle.
        Abort = 1'b1;
        start(3, 1'b0);
        Abort = 1'b0;
        check("startabort_busy", 32'(Busy), 32'd0);
        check("startabort_done", 32'(Done), 32'd0);
        $display("txn start+abort");

        // Write to entry 1 and a new Start during RUN are both ignored.
        start(3, 1'b0);
        Wr_en = 1'b1; Wr_addr = 3'd1; Wr_delay = 16'd5; Wr_pat = 3'b000;
        Start = 1'b1; Len = 4'd1; Loop = 1'b1;
        exp_seq = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b101};
        expect_seq("run_wr");
        Loop = 1'b0;
        start(3, 1'b0);
        exp_seq = '{3'b010, 3'b111, 3'b111, 3'b111, 3'b101};
        expect_seq("replay");

        // Reset during entry 1, then immediate replay of the cleared table.
        start(3, 1'b0);
        tick();
        check("mid_step", 32'(Step), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_out", 32'(Out), 32'h7);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_step", 32'(Step), 32'd0);
        start(3, 1'b0);
        exp_seq = '{3'b111, 3'b111, 3'b111};
        expect_seq("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, meaning the number of output channels (bit 0 = Run, bit 1 = Continue, bit 2 = Reset by convention).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of table entries; DEPTH SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter DLY_W, default 16, meaning the width of each entry's delay field.
REQ-004 The block SHALL have parameter IDLE_PAT, N_CH bits, default all-ones, meaning the pattern driven when not running (active-low buttons released).
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port Start, input, 1 bit: level-sampled request to begin playback.
REQ-008 The block SHALL have port Abort, input, 1 bit: stop playback immediately.
REQ-009 The block SHALL have port Loop, input, 1 bit: sampled at Start; 1 = repeat the table, 0 = one-shot.
REQ-010 The block SHALL have port Len, input, log2(DEPTH)+1 bits: number of entries to play, sampled at Start.
REQ-011 The block SHALL have port Wr_en, input, 1 bit: table write strobe.
REQ-012 The block SHALL have port Wr_addr, input, log2(DEPTH) bits: table write index.
REQ-013 The block SHALL have port Wr_delay, input, DLY_W bits: hold time of the entry, in cycles.
REQ-014 The block SHALL have port Wr_pat, input, N_CH bits: output pattern of the entry.
REQ-015 The block SHALL have port Out, output, N_CH bits: registered channel outputs.
REQ-016 The block SHALL have port Busy, output, 1 bit: high while in RUN.
REQ-017 The block SHALL have port Done, output, 1 bit: one-cycle pulse at one-shot completion.
REQ-018 The block SHALL have port Step, output, log2(DEPTH) bits: index of the entry being played.

Function
REQ-019 States SHALL be IDLE and RUN only; all outputs SHALL be registered.
REQ-020 Table writes SHALL occur on the Clk edge when Wr_en=1 in IDLE and SHALL be ignored in RUN.
REQ-021 A write in the same cycle as Start SHALL complete before entry 0 is read.
REQ-022 IDLE with Start=1 and Len in 1..DEPTH: next cycle SHALL be RUN, Step=0, Out=pat[0], Busy=1, and the delay counter SHALL be loaded with max(delay[0],1).
REQ-023 IDLE with Start=1 and Len=0 or Len>DEPTH: the block SHALL stay in IDLE and pulse Done for 1 cycle; Out SHALL remain IDLE_PAT.
REQ-024 Each entry k SHALL hold Out=pat[k] for exactly max(delay[k],1) cycles; delay=0 SHALL be treated as 1.
REQ-025 In the final cycle of entry k with k<Len-1, the next cycle SHALL show Step=k+1 and Out=pat[k+1].
REQ-026 At the final cycle of entry Len-1 with Loop=1, Step SHALL wrap to 0 with no gap cycle and Done SHALL NOT pulse.
REQ-027 At the final cycle of entry Len-1 with Loop=0, the next cycle SHALL be IDLE with Out=IDLE_PAT, Busy=0, Done=1 (one cycle), and Step=0.
REQ-028 One-shot Busy duration SHALL equal the sum over k<Len of max(delay[k],1) cycles.
REQ-029 Start, Loop, and Len SHALL be ignored while in RUN.
REQ-030 Abort=1 SHALL force IDLE on the next edge (Out=IDLE_PAT, Busy=0, Step=0) without pulsing Done, and Abort SHALL have priority over Start and over step advance.
REQ-031 Abort in IDLE SHALL have no effect, and Start with Abort in the same cycle SHALL stay in IDLE.
REQ-032 The delay counter SHALL be DLY_W bits and SHALL never underflow.

Reset
REQ-033 Reset=1 SHALL on the next edge set state IDLE, Out=IDLE_PAT, Busy=0, Done=0, Step=0, and the counter to 0, with priority over all inputs.
REQ-034 Reset SHALL clear all table entries to delay=0 and pat=IDLE_PAT.
REQ-035 Reset mid-RUN SHALL NOT pulse Done, and a new Start SHALL be accepted the first cycle after Reset deasserts.

Verification
REQ-036 Verification SHALL cover: entries {pat 110, d 2}, {pat 111, d 3}, {pat 101, d 1}, Len=3, Loop=0, Start -> Out 110 for 2 cycles, 111 for 3, 101 for 1, then 111 with Done=1 for one cycle; Busy high for 6 cycles.
REQ-037 Verification SHALL cover: same table, Loop=1 -> Step sequence 0,0,1,1,1,2,0,0,... continuing, with Done never asserted; Abort at cycle 9 -> Out=111 and Busy=0 next cycle.
REQ-038 Verification SHALL cover: entry 0 with delay=0, Len=1, Loop=0 -> Out=pat[0] for exactly 1 cycle, then Done.
REQ-039 Verification SHALL cover: Len=0 Start -> Done pulse, Busy stays 0, and Out stays 111; Len=9 (DEPTH=8) -> same.
REQ-040 Verification SHALL cover: Wr_en to entry 1 during RUN -> table unchanged, confirmed by a later replay; Start during RUN -> ignored.
REQ-041 Verification SHALL cover: Reset asserted during entry 1 of RUN -> next cycle Out=111, Busy=0, no Done; a subsequent replay shows all entries at IDLE_PAT for 1 cycle each.
